// File: rtl/glip_rx_deframer_pkg.sv
// Shared types for the GLIP receive deframer: FSM state encoding
// and the width of the completed-frame counter.
package glip_rx_deframer_pkg;

    typedef enum logic {
        HEADER  = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/glip_rx_deframer.sv
// GLIP receive deframer: strips a length header from each inbound frame and
// forwards the payload words with a last-word marker.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_data/valid/ready - inbound channel (header word, then N payload words)
//   out_data/valid/ready/last - payload stream, out_last marks final word
//   frame_cnt           - completed frames (zero-length included), wraps
//   zero_len            - one-cycle pulse after a length-0 header
module glip_rx_deframer
    import glip_rx_deframer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   zero_len
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] remaining_nxt;
    logic             hdr_zero;
    logic             pay_fire;
    logic             last_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HEADER;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        in_ready      = 1'b0;
        hdr_zero      = 1'b0;
        pay_fire      = 1'b0;
        last_fire     = 1'b0;
        if (!rst) begin
            unique case (state)
                HEADER: begin
                    // Headers never touch the output register, so a held
                    // last word of the previous frame is left alone.
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (in_data == '0) begin
                            hdr_zero = 1'b1;
                        end else begin
                            remaining_nxt = in_data;
                            state_nxt     = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    // Accept when the output slot is empty or drains now.
                    in_ready = !out_valid || out_ready;
                    if (in_valid && in_ready) begin
                        pay_fire      = 1'b1;
                        remaining_nxt = remaining - WIDTH'(1);
                        if (remaining == WIDTH'(1)) begin
                            last_fire = 1'b1;
                            state_nxt = HEADER;
                        end
                    end
                end
                default: state_nxt = HEADER;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
            zero_len  <= 1'b0;
        end else begin
            zero_len <= hdr_zero;
            if (hdr_zero || last_fire) begin
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end
            if (pay_fire) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
                out_last  <= last_fire;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_glip_rx_deframer.sv
// Self-checking bench for glip_rx_deframer: directed and random frame
// streams compared against a frame-level model of the deframer.
module tb_glip_rx_deframer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic [15:0]  frame_cnt;
    logic         zero_len;

    glip_rx_deframer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_cnt (frame_cnt),
        .zero_len  (zero_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } word_t;

    int    checks = 0;
    int    errors = 0;
    word_t got[$];
    int    got_t[$];
    word_t exp_q[$];
    int    exp_fr;
    int    exp_zl;
    int    exp_frames = 0;
    int    zl_cnt = 0;
    int    hold_viol = 0;
    int    tick = 0;
    logic  pv = 1'b0, pr = 1'b0, prst = 1'b1, pl = 1'b0;
    logic [W-1:0] pd = '0;

    // Output monitor: samples at negedge, away from the active edge.
    always @(negedge clk) begin
        tick++;
        if (zero_len === 1'b1) zl_cnt++;
        if (pv && !pr && !prst) begin
            if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl)
                hold_viol++;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
            got.push_back(word_t'({out_data, out_last}));
            got_t.push_back(tick);
        end
        pv = out_valid; pr = out_ready; prst = rst;
        pd = out_data;  pl = out_last;
    end

    // Frame-level model: header N followed by N words; last flag on word N.
    task automatic model(input logic [W-1:0] s[$]);
        int i;
        int n;
        exp_q.delete();
        exp_fr = 0;
        exp_zl = 0;
        i = 0;
        while (i < s.size()) begin
            n = int'(s[i]);
            i++;
            if (n == 0) exp_zl++;
            for (int k = 0; k < n; k++) begin
                exp_q.push_back(word_t'({s[i], (k == n - 1)}));
                i++;
            end
            exp_fr++;
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0: return 1'b1;
            1: return 1'($urandom_range(1));
            2: return (cyc % 3) == 0;
            default: return cyc >= 6;
        endcase
    endfunction

    task automatic drive(input logic [W-1:0] s[$], input int rmode,
                         input int gap, input int stop_after,
                         output int cyc);
        int idx;
        logic fire;
        idx = 0;
        cyc = 0;
        while (idx < s.size() && idx < stop_after && cyc < 5000) begin
            @(posedge clk); #2;
            in_valid  = ($urandom_range(99) >= gap);
            in_data   = in_valid ? s[idx] : W'($urandom);
            out_ready = ready_for(rmode, cyc);
            @(negedge clk);
            fire = in_valid && in_ready;
            cyc++;
            if (fire) idx++;
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
        if (cyc >= 5000) begin
            checks++; errors++;
            $display("FAIL drive_timeout accepted %0d want %0d", idx, s.size());
        end
    endtask

    task automatic run_stream(input logic [W-1:0] s[$], input int rmode,
                              input int gap);
        int cyc;
        int n;
        model(s);
        got.delete();
        got_t.delete();
        hold_viol = 0;
        drive(s, rmode, gap, s.size(), cyc);
        n = 0;
        while (n < 500) begin
            out_ready = ready_for(rmode, cyc);
            @(negedge clk);
            if (got.size() >= exp_q.size() && !out_valid) break;
            @(posedge clk); #2;
            cyc++;
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d want %0d", got.size(), exp_q.size());
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        exp_frames = (exp_frames + exp_fr) % 65536;
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        rst = 1'b1; in_valid = 1'b1; in_data = 16'h0003; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset got %b want 0", in_ready);
        end
        @(posedge clk); #2;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        exp_frames = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({out_valid, out_last, out_data, frame_cnt, zero_len} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v%b l%b d%h fc%h z%b want 0",
                     out_valid, out_last, out_data, frame_cnt, zero_len);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_header_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_single_frame();
        logic [W-1:0] s[$];
        s = '{16'd3, 16'h00A1, 16'h00A2, 16'h00A3};
        run_stream(s, 0, 0);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_count got %0d want %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_word%0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
        if (got_t.size() == 3) begin
            checks++;
            if (got_t[2] - got_t[0] != 2) begin
                errors++;
                $display("FAIL single_spacing got %0d want 2", got_t[2] - got_t[0]);
            end
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL single_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_zero_len();
        logic [W-1:0] s[$];
        int zl0;
        zl0 = zl_cnt;
        s = '{16'd0, 16'd1, 16'h00B1};
        run_stream(s, 0, 0);
        checks++;
        if (zl_cnt - zl0 != exp_zl) begin
            errors++;
            $display("FAIL zl_pulses got %0d want %0d", zl_cnt - zl0, exp_zl);
        end
        checks++;
        if (got.size() != 1 || (got.size() == 1 && got[0] !== exp_q[0])) begin
            errors++;
            $display("FAIL zl_output got n=%0d want %h", got.size(), exp_q[0]);
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL zl_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_stall_toggle();
        logic [W-1:0] s[$];
        s = '{16'd4, 16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4};
        run_stream(s, 2, 0);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count got %0d want %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_word%0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d changes want 0", hold_viol);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s[$];
        s = '{16'd2, 16'h00D1, 16'h00D2, 16'd1, 16'h00E1};
        run_stream(s, 3, 0);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_word%0d got %h want %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (hold_viol != 0 || frame_cnt !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL b2b_state got hold=%0d fc=%0d want 0 fc=%0d",
                     hold_viol, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] s[$];
        int cyc;
        s = '{16'd5, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015};
        drive(s, 0, 0, 3, cyc);
        apply_reset();
        s = '{16'd1, 16'h00F1};
        run_stream(s, 0, 0);
        checks++;
        if (got.size() != 1 || (got.size() == 1 && got[0] !== exp_q[0])) begin
            errors++;
            $display("FAIL midrst_output got n=%0d want only %h", got.size(), exp_q[0]);
        end
        checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL midrst_frame_cnt got %0d want %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] s[$];
        int n;
        for (int it = 0; it < 3; it++) begin
            s.delete();
            for (int f = 0; f < 15; f++) begin
                n = $urandom_range(5);
                s.push_back(W'(n));
                for (int k = 0; k < n; k++) s.push_back(W'($urandom));
            end
            run_stream(s, 1, 30);
            checks++;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count got %0d want %0d", it, got.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < got.size()) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_word%0d got %h want %h", it, i, got[i], exp_q[i]);
                end
            end
            checks++;
            if (hold_viol != 0 || frame_cnt !== 16'(exp_frames)) begin
                errors++;
                $display("FAIL rand%0d_state got hold=%0d fc=%0d want 0 fc=%0d",
                         it, hold_viol, frame_cnt, exp_frames);
            end
        end
    endtask

    task automatic test_frame_cnt_wrap();
        int n;
        int busy;
        int zl0;
        int lim;
        apply_reset();
        got.delete();
        zl0 = zl_cnt;
        n = 0;
        busy = 0;
        lim = 0;
        @(posedge clk); #2;
        in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        while (n < 65535 && lim < 70000) begin
            @(negedge clk);
            if (in_ready) n++; else busy++;
            lim++;
            if (n < 65535) @(posedge clk);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_ffff got %h want ffff (accepted %0d)", frame_cnt, n);
        end
        @(posedge clk); #2;
        in_valid = 1'b1;
        @(negedge clk);
        if (!in_ready) busy++;
        @(posedge clk); #2;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero got %h want 0000", frame_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (zl_cnt - zl0 != 65536 || busy != 0) begin
            errors++;
            $display("FAIL wrap_pulses got %0d busy=%0d want 65536 busy=0",
                     zl_cnt - zl0, busy);
        end
        checks++;
        if (got.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_side_effect got n=%0d v=%b want 0", got.size(), out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single_frame();
        test_zero_len();
        test_stall_toggle();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        test_frame_cnt_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
